// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Imported by instr_fetch and anything that talks to its decode interface.
package instr_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DEF_PC_STEP = 4;

  localparam logic [XLEN-1:0] DEF_RESET_PC = '0;
  localparam logic [XLEN-1:0] NOP_INSTR    = '0;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_slot_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, drives the synchronous instruction memory and
// presents instructions to decode through a valid/stall handshake with a skid buffer.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned     PC_STEP  = DEF_PC_STEP
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  output logic            misalign_err
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] f_pc_q, f_pc_d;
  logic            f_valid_q, f_valid_d;
  fetch_slot_t     hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic            misalign_q, misalign_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      f_pc_q       <= '0;
      f_valid_q    <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      f_pc_q       <= f_pc_d;
      f_valid_q    <= f_valid_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  // Redirect beats stall; while stalled the memory word in flight is parked in
  // the hold buffer because the memory will not return it again.
  always_comb begin
    pc_d         = pc_q;
    f_pc_d       = f_pc_q;
    f_valid_d    = f_valid_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    misalign_d   = misalign_q;
    if (redirect) begin
      pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
      f_valid_d    = 1'b0;
      hold_valid_d = 1'b0;
      misalign_d   = misalign_q | is_misaligned(redirect_pc);
    end else if (stall) begin
      f_valid_d = 1'b0;
      if (!hold_valid_q && f_valid_q) begin
        hold_d.instr = imem_data;
        hold_d.pc    = f_pc_q;
        hold_valid_d = 1'b1;
      end
    end else begin
      f_pc_d       = pc_q;
      f_valid_d    = 1'b1;
      pc_d         = pc_q + XLEN'(PC_STEP);
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    instr    = NOP_INSTR;
    instr_pc = '0;
    if (hold_valid_q) begin
      instr    = hold_q.instr;
      instr_pc = hold_q.pc;
    end else if (f_valid_q) begin
      instr    = imem_data;
      instr_pc = f_pc_q;
    end
  end

  assign instr_valid  = hold_valid_q | f_valid_q;
  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected (pc, instr) pairs are queued as
// stimulus is driven and retired on each decode transfer.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misalign_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err)
  );

  function automatic logic [31:0] memw(input logic [4:0] idx);
    case (idx)
      5'd0:    return 32'h0001_F820;
      5'd1:    return 32'h0021_F020;
      5'd2:    return 32'h0022_E820;
      5'd3:    return 32'h0043_E020;
      5'd4:    return 32'h0065_D820;
      default: return 32'hA5A5_0000 | {27'b0, idx};
    endcase
  endfunction

  // Synchronous memory decoding only addr[6:0]
  always @(posedge clk) imem_data <= memw(imem_addr[6:2]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = memw(pc[6:2]);
    sb.push_back(e);
  endtask

  // One clock cycle: apply inputs, check the presented instruction against the
  // scoreboard (pop on transfer, peek while stalled), then advance one edge.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc);
    exp_t e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (instr_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pc", instr_pc, 32'hFFFF_FFFF);
      end else begin
        if (st) e = sb[0];
        else    e = sb.pop_front();
        chk(st ? "held_pc" : "xfer_pc", instr_pc, e.pc);
        chk(st ? "held_instr" : "xfer_instr", instr, e.ins);
      end
    end else begin
      chk("bubble_instr", instr, 32'h0);
      chk("bubble_pc", instr_pc, 32'h0);
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    rst_n = 1'b1;

    // Sequential stream after reset release
    push_exp(32'd0); push_exp(32'd4); push_exp(32'd8);
    cyc(1'b0, 1'b0, '0);
    chk("addr_4", imem_addr, 32'd4);
    chk("first_valid", 32'(instr_valid), 32'd1);
    cyc(1'b0, 1'b0, '0);
    chk("addr_8", imem_addr, 32'd8);

    // Three stalled cycles holding pc 4, then release
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("stall_addr", imem_addr, 32'd8);
    end
    cyc(1'b0, 1'b0, '0);
    chk("addr_12", imem_addr, 32'd12);
    push_exp(32'd12);
    cyc(1'b0, 1'b0, '0);

    // Redirect to 16 while streaming
    cyc(1'b0, 1'b1, 32'd16);
    chk("redir_bubble", 32'(instr_valid), 32'd0);
    cyc(1'b0, 1'b0, '0);
    push_exp(32'd16); push_exp(32'd20); push_exp(32'd24); push_exp(32'd28);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0);

    // Redirect together with stall while the hold buffer is full
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'd40);
    void'(sb.pop_front());
    chk("redir_stall_bubble", 32'(instr_valid), 32'd0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    push_exp(32'd40); push_exp(32'd44); push_exp(32'd48);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);

    // Misaligned redirect target
    chk("misalign_before", 32'(misalign_err), 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_000E);
    chk("misalign_set", 32'(misalign_err), 32'd1);
    chk("misalign_addr", imem_addr, 32'd12);
    cyc(1'b0, 1'b0, '0);
    push_exp(32'd12); push_exp(32'd16);
    cyc(1'b0, 1'b0, '0);

    // Aligned redirect to 124 and wrap of the 7-bit memory decode
    cyc(1'b0, 1'b1, 32'd124);
    chk("misalign_sticky", 32'(misalign_err), 32'd1);
    cyc(1'b0, 1'b0, '0);
    chk("addr_128", imem_addr, 32'd128);
    push_exp(32'd124); push_exp(32'd128); push_exp(32'd132);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);

    // Reset asserted mid-stall takes effect without a clock edge
    cyc(1'b1, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_misalign", 32'(misalign_err), 32'd0);
    sb.delete();
    stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(32'd0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
